// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform-to-UART packet scheduler.
`default_nettype none

package wave_pkg;

  localparam int SRC_IDX_W = 4;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    CHAN   = 3'd2,
    WAIT_S = 3'd3,
    SEND_S = 3'd4,
    CSUM   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wave_src_select.sv
// Source selection: lowest-set-bit manual select or dwell-paced round-robin pointer.
`default_nettype none

module wave_src_select
  import wave_pkg::*;
#(
  parameter int NUM_SRC    = 7,
  parameter int DWELL_PKTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_sel,
  input  logic                 auto_en,
  input  logic                 advance,
  output logic [SRC_IDX_W-1:0] next_src,
  output logic                 next_valid
);

  logic [SRC_IDX_W-1:0] ptr;
  logic [SRC_IDX_W-1:0] ptr_nxt;
  logic [7:0]           dwell;
  logic [7:0]           dwell_nxt;
  logic [SRC_IDX_W-1:0] man_idx;

  // Scan downward so the lowest set bit is the last assignment and wins.
  always_comb begin
    man_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_sel[k]) man_idx = SRC_IDX_W'(k);
    end
  end

  always_comb begin
    ptr_nxt   = ptr;
    dwell_nxt = dwell;
    if (advance) begin
      if (dwell + 8'd1 == 8'(DWELL_PKTS)) begin
        dwell_nxt = 8'd0;
        ptr_nxt   = (ptr == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : ptr + 1'b1;
      end else begin
        dwell_nxt = dwell + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr   <= '0;
      dwell <= 8'd0;
    end else begin
      ptr   <= ptr_nxt;
      dwell <= dwell_nxt;
    end
  end

  // The post-advance pointer is exposed so a back-to-back packet picks up the new source.
  assign next_src   = auto_en ? ptr_nxt : man_idx;
  assign next_valid = auto_en | (|src_sel);

endmodule

`default_nettype wire

// File: rtl/wave_tx_scheduler.sv
// Frames generator samples into header/channel/sample packets for the UART transmitter.
// Optional trailing checksum byte enabled by WAVE_TX_CHECKSUM_EN.
`default_nettype none

module wave_tx_scheduler
  import wave_pkg::*;
#(
  parameter int          NUM_SRC    = 7,
  parameter int          DATA_W     = 8,
  parameter int          PKT_LEN    = 16,
  parameter int          DWELL_PKTS = 4,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_sel,
  input  logic                      auto_en,
  input  logic                      stream_en,
  input  logic                      sample_stb,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [3:0]                active_src,
  output logic                      busy,
  output logic                      overrun
);

  if (DATA_W != 8) begin : g_data_w_check
    $error("wave_tx_scheduler: DATA_W must be 8");
  end

  state_t               state;
  state_t               state_nxt;
  logic                 auto_pkt;
  byte_t                sample_q;
  byte_t                stb_slice;
  logic [7:0]           cnt;
  logic                 xfer;
  logic                 last;
  logic                 eop;
  logic                 start;
  logic                 load;
  logic [SRC_IDX_W-1:0] next_src;
  logic                 next_valid;
`ifdef WAVE_TX_CHECKSUM_EN
  byte_t                acc;
`endif

  wave_src_select #(
    .NUM_SRC    (NUM_SRC),
    .DWELL_PKTS (DWELL_PKTS)
  ) u_src_select (
    .clk        (clk),
    .reset      (reset),
    .src_sel    (src_sel),
    .auto_en    (auto_en),
    .advance    (eop && auto_pkt),
    .next_src   (next_src),
    .next_valid (next_valid)
  );

  assign xfer  = tx_valid && tx_ready;
  assign last  = (cnt + 8'd1 == 8'(PKT_LEN));
  assign start = stream_en && next_valid;
`ifdef WAVE_TX_CHECKSUM_EN
  assign eop   = (state == CSUM) && xfer;
`else
  assign eop   = (state == SEND_S) && xfer && last;
`endif
  assign load  = ((state == IDLE) || eop) && start;

  always_comb begin
    stb_slice = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_src == 4'(k)) stb_slice = src_data[k*DATA_W +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = HDR;
      HDR:    if (xfer) state_nxt = CHAN;
      CHAN:   if (xfer) state_nxt = WAIT_S;
      WAIT_S: if (sample_stb) state_nxt = SEND_S;
      SEND_S: begin
        if (xfer) begin
          if (last) begin
`ifdef WAVE_TX_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = start ? HDR : IDLE;
`endif
          end else begin
            state_nxt = sample_stb ? SEND_S : WAIT_S;
          end
        end
      end
`ifdef WAVE_TX_CHECKSUM_EN
      CSUM:   if (xfer) state_nxt = start ? HDR : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != IDLE);
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      CHAN: begin
        tx_valid = 1'b1;
        tx_data  = {4'h0, active_src};
      end
      SEND_S: begin
        tx_valid = 1'b1;
        tx_data  = sample_q;
      end
`ifdef WAVE_TX_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00 - acc;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_src <= 4'h0;
      auto_pkt   <= 1'b0;
      sample_q   <= 8'h00;
      cnt        <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      overrun <= (state == SEND_S) && sample_stb && !xfer;
      if (load) begin
        active_src <= next_src;
        auto_pkt   <= auto_en;
      end
      if ((state == CHAN) && xfer) cnt <= 8'h00;
      if ((state == SEND_S) && xfer) cnt <= cnt + 8'd1;
      // A strobe coinciding with a non-final transfer refills the register directly.
      if (((state == WAIT_S) && sample_stb) ||
          ((state == SEND_S) && sample_stb && xfer && !last))
        sample_q <= stb_slice;
    end
  end

`ifdef WAVE_TX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= 8'h00;
    end else begin
      if (state == HDR) acc <= 8'h00;
      if ((state == CHAN) && xfer) acc <= acc + {4'h0, active_src};
      if ((state == SEND_S) && xfer) acc <= acc + sample_q;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wave_tx_scheduler.sv
// Randomized scoreboard bench for wave_tx_scheduler with a byte-queue packet model.
`timescale 1ns/1ps
`default_nettype none

module tb_wave_tx_scheduler;

  localparam int         NUM_SRC    = 7;
  localparam int         PKT_LEN    = 4;
  localparam int         DWELL_PKTS = 2;
  localparam logic [7:0] HDR        = 8'hA5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_SRC*8-1:0] src_data = '0;
  logic [NUM_SRC-1:0]   src_sel = '0;
  logic                 auto_en = 1'b0;
  logic                 stream_en = 1'b0;
  logic                 sample_stb = 1'b0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b0;
  logic [3:0]           active_src;
  logic                 busy;
  logic                 overrun;

  always #5 clk = ~clk;

  wave_tx_scheduler #(
    .NUM_SRC    (NUM_SRC),
    .DATA_W     (8),
    .PKT_LEN    (PKT_LEN),
    .DWELL_PKTS (DWELL_PKTS),
    .HDR_BYTE   (HDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src_data   (src_data),
    .src_sel    (src_sel),
    .auto_en    (auto_en),
    .stream_en  (stream_en),
    .sample_stb (sample_stb),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .active_src (active_src),
    .busy       (busy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [NUM_SRC-1:0] v);
    for (int k = 0; k < NUM_SRC; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Reference model: bytes still to be presented in the current packet, plus
  // the scoreboard of every byte the packet will ever present, in order.
  logic [7:0] m_out[$];
  logic [7:0] sb[$];
  bit         m_busy = 0, m_samp_phase = 0, m_csum_phase = 0, m_auto = 0, m_ovr = 0;
  int         m_src = 0, m_ptr = 0, m_dwell = 0, m_capt = 0, m_ovr_total = 0;
  logic [7:0] m_sum = 8'h00;
  int         dut_ovr_cnt = 0;

  always @(posedge clk) begin : model
    bit         xfer, eop, can_capture;
    logic [7:0] s, chan;
    if (!reset) begin
      m_out.delete();
      sb.delete();
      m_busy = 0; m_samp_phase = 0; m_csum_phase = 0; m_auto = 0; m_ovr = 0;
      m_src = 0; m_ptr = 0; m_dwell = 0; m_capt = 0; m_sum = 8'h00;
    end else begin
      xfer = (m_out.size() > 0) && tx_ready;
      eop  = 0;
      m_ovr = sample_stb && m_samp_phase && !m_csum_phase && (m_out.size() > 0) && !xfer;
      if (m_ovr) m_ovr_total++;
      can_capture = sample_stb && m_samp_phase && (m_capt < PKT_LEN) &&
                    ((m_out.size() == 0) || ((m_out.size() == 1) && xfer));
      if (xfer) begin
        void'(m_out.pop_front());
        if (!m_samp_phase && m_out.size() == 0) m_samp_phase = 1;
      end
      if (can_capture) begin
        s = src_data[m_src*8 +: 8];
        m_out.push_back(s);
        sb.push_back(s);
        m_capt++;
        m_sum = m_sum + s;
      end
      if (xfer && m_samp_phase && (m_capt == PKT_LEN) && (m_out.size() == 0)) begin
`ifdef WAVE_TX_CHECKSUM_EN
        if (!m_csum_phase) begin
          m_csum_phase = 1;
          m_out.push_back(8'h00 - m_sum);
          sb.push_back(8'h00 - m_sum);
        end else begin
          eop = 1;
        end
`else
        eop = 1;
`endif
      end
      if (eop) begin
        m_busy = 0;
        if (m_auto) begin
          m_dwell++;
          if (m_dwell == DWELL_PKTS) begin
            m_dwell = 0;
            m_ptr   = (m_ptr + 1) % NUM_SRC;
          end
        end
      end
      if (!m_busy && stream_en && (auto_en || (src_sel != 0))) begin
        m_src = auto_en ? m_ptr : lowest_set(src_sel);
        m_auto = auto_en;
        chan = 8'(m_src);
        m_out.push_back(HDR); m_out.push_back(chan);
        sb.push_back(HDR);    sb.push_back(chan);
        m_sum = chan;
        m_capt = 0; m_samp_phase = 0; m_csum_phase = 0;
        m_busy = 1;
      end
    end
  end

  // Monitor: compares DUT outputs against the model, pops the scoreboard on transfers.
  always @(negedge clk) begin : monitor
    logic [7:0] exp_b;
    check("tx_valid", tx_valid, m_out.size() > 0);
    check("busy", busy, m_busy);
    check("overrun", overrun, m_ovr);
    if (m_busy) check("active_src", active_src, m_src);
    if (overrun === 1'b1) dut_ovr_cnt++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
      end else begin
        exp_b = sb.pop_front();
        check("tx_data", tx_data, exp_b);
      end
    end
  end

  task automatic rand_cycles(input int n, input int stb_pct, input int rdy_pct, input bit rand_sel);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NUM_SRC; k++) src_data[k*8 +: 8] = 8'($urandom);
      sample_stb = ($urandom_range(99) < stb_pct);
      tx_ready   = ($urandom_range(99) < rdy_pct);
      if (rand_sel && ($urandom_range(19) == 0)) src_sel = NUM_SRC'($urandom);
    end
  endtask

  // Advance randomly until a sample is presented, bounded by a cycle budget.
  task automatic wait_pending_sample(input string name);
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (m_samp_phase && !m_csum_phase && m_out.size() > 0) found = 1;
      else begin
        for (int k = 0; k < NUM_SRC; k++) src_data[k*8 +: 8] = 8'($urandom);
        sample_stb = ($urandom_range(99) < 40);
        tx_ready   = 1'b1;
      end
    end
    check(name, found, 1);
  endtask

  task automatic drain(input string name);
    bit idle = 0;
    stream_en = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      rand_cycles(1, 50, 80, 0);
      if (!m_busy) idle = 1;
    end
    check(name, idle, 1);
  endtask

  initial begin
    int ovr_before;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_active_src", active_src, 0);
    reset = 1'b1;

    // Manual single packet from a one-cycle stream_en pulse, sources 1 and 2 selected.
    src_sel = 7'b0000110;
    stream_en = 1'b1;
    @(posedge clk); #1;
    stream_en = 1'b0;
    check("manual_src", active_src, 1);
    rand_cycles(250, 30, 70, 0);
    check("manual_done_idle", busy, 0);

    // Manual streaming with select switches changing mid-packet.
    stream_en = 1'b1;
    rand_cycles(600, 35, 75, 1);
    drain("drain_manual");

    // No source selected: must stay idle.
    src_sel = '0;
    stream_en = 1'b1;
    rand_cycles(50, 50, 100, 0);
    check("nosel_idle", busy, 0);
    check("nosel_valid", tx_valid, 0);

    // Auto round-robin, then a manual interlude, then auto again.
    auto_en = 1'b1;
    src_sel = 7'b1000000;
    rand_cycles(1500, 40, 90, 1);
    auto_en = 1'b0;
    src_sel = 7'b0010000;
    rand_cycles(300, 40, 90, 1);
    auto_en = 1'b1;
    rand_cycles(400, 40, 90, 0);

    // Transmitter stall with two strobes while a sample is held.
    wait_pending_sample("stall_reach");
    ovr_before = dut_ovr_cnt;
    tx_ready = 1'b0;
    sample_stb = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample_stb = (i == 10) || (i == 30);
      @(posedge clk); #1;
    end
    sample_stb = 1'b0;
    @(posedge clk); #1;
    check("stall_overruns", dut_ovr_cnt - ovr_before, 2);
    rand_cycles(200, 40, 90, 0);

    // Reset mid-sample, then restart.
    wait_pending_sample("reset_reach");
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_active_src", active_src, 0);
    check("midrst_overrun", overrun, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("restart_hdr", tx_data, HDR);
    rand_cycles(500, 40, 80, 1);

    drain("drain_final");
    rand_cycles(5, 0, 100, 0);
    check("sb_empty", sb.size(), 0);
    check("ovr_total", dut_ovr_cnt, m_ovr_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
